// File: rtl/cab_led_driver_if.sv
// Write-side request bus into the cabinet LED driver.
// The system-register decode is the master; the driver is the slave.
interface cab_led_driver_if;
    logic       WR_EN;
    logic [1:0] WR_SEL;
    logic [7:0] WR_DATA;
    logic       WR_READY;

    modport master (output WR_EN, output WR_SEL, output WR_DATA, input WR_READY);
    modport slave  (input WR_EN, input WR_SEL, input WR_DATA, output WR_READY);
endinterface

// File: rtl/cab_led_driver.sv
// Cabinet LED driver: queues tagged byte writes and sequences the shared
// LED_DATA bus plus three active-low LED_LATCH strobes. Each board captures
// its byte on the falling edge of its strobe.
module cab_led_driver #(
    parameter int SETUP_W = 2,   // cycles of stable data before the strobe falls (1..15)
    parameter int PULSE_W = 4,   // cycles the strobe is held low (1..15)
    parameter int DEPTH   = 4    // request FIFO entries, power of two (2..16)
) (
    input  logic              CLK_6MB,
    input  logic              nRESET,
    cab_led_driver_if.slave   wr,
    output logic [7:0]        LED_DATA,
    output logic [2:0]        LED_LATCH,
    output logic              BUSY,
    output logic              OVF
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0]    SETUP_LD = 4'(SETUP_W - 1);
    localparam logic [3:0]    PULSE_LD = 4'(PULSE_W - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // FIFO state
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    // Sequencer state
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    sel_q, sel_d;
    logic [2:0]    latch_q, latch_d;

    logic          push, pop, empty, full;
    entry_t        head;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign push  = wr.WR_EN && !full;
    assign head  = mem_q[rd_ptr_q];

    // Active-low strobe pattern for a destination; broadcast pulls all three.
    function automatic logic [2:0] strobe_pat(input logic [1:0] s);
        logic [2:0] p;
        p = 3'b111;
        if (s == 2'd3) begin
            p = 3'b000;
        end else begin
            p[s] = 1'b0;
        end
        return p;
    endfunction

    // FIFO bookkeeping: push on accepted write, pop when the sequencer takes the head.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{sel: wr.WR_SEL, data: wr.WR_DATA};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        // A write offered while full is lost; remember that it happened.
        if (wr.WR_EN && full) begin
            ovf_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sequencer: next state, dwell counter, data/select capture and next strobe value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sel_d   = sel_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    data_d  = head.data;
                    sel_d   = head.sel;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = PULSE_LD;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                // Chaining straight into SETUP keeps the back-to-back period at
                // SETUP_W+PULSE_W+1 while still guaranteeing a high cycle here.
                if (!empty) begin
                    pop     = 1'b1;
                    data_d  = head.data;
                    sel_d   = head.sel;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Strobe is registered from the next state so it is glitch-free and
        // lines up with the edge the FSM enters/leaves STROBE.
        latch_d = (state_d == STROBE) ? strobe_pat(sel_d) : 3'b111;
    end

    // All state registers; reset drops the strobes high immediately.
    always_ff @(posedge CLK_6MB or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            data_q   <= 8'h00;
            sel_q    <= 2'd0;
            latch_q  <= 3'b111;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            latch_q  <= latch_d;
        end
    end

    assign wr.WR_READY = !full;
    assign LED_DATA    = data_q;
    assign LED_LATCH   = latch_q;
    assign BUSY        = !empty || (state_q != IDLE);
    assign OVF         = ovf_q;
endmodule

// File: tb/tb_cab_led_driver.sv
// Bench for cab_led_driver: two instances (default timing and the 1/1 corner)
// share one stimulus stream. Each has a timeline model: an accepted write is
// taken at max(push+1, previous take + SETUP_W+PULSE_W+1), and every output is
// predicted from those take times. Expected strobes go into a scoreboard queue
// that a monitor drains whenever a strobe falls.
module tb_cab_led_driver;
    localparam int NI    = 2;
    localparam int DEPTH = 4;
    localparam int S_TAB [NI] = '{2, 1};
    localparam int P_TAB [NI] = '{4, 1};

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [1:0] wr_sel  = 2'd0;
    logic [7:0] wr_data = 8'h00;
    int         total   = 0;
    int         bad     = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] pat(input logic [1:0] s);
        return (s == 2'd3) ? 3'b000 : ~(3'b001 << s);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int S = S_TAB[g];
        localparam int P = P_TAB[g];
        localparam int T = S + P + 1;

        logic [7:0] led_data;
        logic [2:0] led_latch;
        logic       busy, ovf;

        cab_led_driver_if bus ();
        assign bus.WR_EN   = wr_en;
        assign bus.WR_SEL  = wr_sel;
        assign bus.WR_DATA = wr_data;

        cab_led_driver #(.SETUP_W(S), .PULSE_W(P), .DEPTH(DEPTH)) dut (
            .CLK_6MB  (clk),
            .nRESET   (rst_n),
            .wr       (bus.slave),
            .LED_DATA (led_data),
            .LED_LATCH(led_latch),
            .BUSY     (busy),
            .OVF      (ovf)
        );

        // accepted transactions: push edge, take edge, destination, byte
        int         push_t [$];
        int         pop_t  [$];
        logic [1:0] sel_m  [$];
        logic [7:0] dat_m  [$];
        // scoreboard of expected strobe falls
        int         sb_edge [$];
        logic [2:0] sb_pat  [$];
        logic [7:0] sb_dat  [$];

        int         edge_n   = 0;
        int         last_pop = -1000;
        int         p_new;
        bit         ovf_exp  = 1'b0;
        logic [2:0] prev_latch = 3'b111;
        logic       e_ready, e_busy;
        logic [2:0] e_latch;
        logic [7:0] e_data;
        logic [2:0] f_pat;
        logic [7:0] f_dat;
        int         f_edge;

        // entries sitting in the FIFO just before edge t
        function automatic int occ(input int t);
            int n = 0;
            foreach (push_t[k]) if (push_t[k] < t && pop_t[k] >= t) n++;
            return n;
        endfunction

        // model: accept or drop the write offered at this edge
        always @(posedge clk) begin
            edge_n++;
            if (!rst_n) begin
                push_t.delete(); pop_t.delete(); sel_m.delete(); dat_m.delete();
                sb_edge.delete(); sb_pat.delete(); sb_dat.delete();
                ovf_exp  = 1'b0;
                last_pop = -1000;
            end else if (wr_en) begin
                if (occ(edge_n) < DEPTH) begin
                    p_new    = (edge_n + 1 > last_pop + T) ? edge_n + 1 : last_pop + T;
                    last_pop = p_new;
                    push_t.push_back(edge_n);
                    pop_t.push_back(p_new);
                    sel_m.push_back(wr_sel);
                    dat_m.push_back(wr_data);
                    sb_edge.push_back(p_new + S);
                    sb_pat.push_back(pat(wr_sel));
                    sb_dat.push_back(wr_data);
                end else begin
                    ovf_exp = 1'b1;
                end
            end
        end

        // monitor: compare every output shortly after each edge; drain scoreboard on strobe falls
        always @(posedge clk) begin
            #1;
            e_ready = (occ(edge_n + 1) < DEPTH);
            e_busy  = 1'b0;
            e_latch = 3'b111;
            e_data  = 8'h00;
            foreach (push_t[k]) begin
                if (push_t[k] <= edge_n && edge_n < pop_t[k] + T) e_busy = 1'b1;
                if (pop_t[k] + S <= edge_n && edge_n < pop_t[k] + S + P) e_latch &= pat(sel_m[k]);
                if (pop_t[k] <= edge_n) e_data = dat_m[k];
            end
            check($sformatf("i%0d ready @%0d", g, edge_n), bus.WR_READY, e_ready);
            check($sformatf("i%0d busy @%0d", g, edge_n), busy, e_busy);
            check($sformatf("i%0d latch @%0d", g, edge_n), led_latch, e_latch);
            check($sformatf("i%0d data @%0d", g, edge_n), led_data, e_data);
            check($sformatf("i%0d ovf @%0d", g, edge_n), ovf, ovf_exp);
            if (prev_latch == 3'b111 && led_latch != 3'b111) begin
                check($sformatf("i%0d strobe expected @%0d", g, edge_n), sb_edge.size() > 0, 1);
                if (sb_edge.size() > 0) begin
                    f_edge = sb_edge.pop_front();
                    f_pat  = sb_pat.pop_front();
                    f_dat  = sb_dat.pop_front();
                    check($sformatf("i%0d fall edge", g), edge_n, f_edge);
                    check($sformatf("i%0d fall pattern @%0d", g, edge_n), led_latch, f_pat);
                    check($sformatf("i%0d fall data @%0d", g, edge_n), led_data, f_dat);
                end
            end
            prev_latch = led_latch;
        end
    end

    task automatic cyc(input logic en, input logic [1:0] s, input logic [7:0] d);
        @(negedge clk);
        wr_en   = en;
        wr_sel  = s;
        wr_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 2'd0, 8'h00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        // reset state
        check("reset latch", gi[0].led_latch, 3'b111);
        check("reset data", gi[0].led_data, 8'h00);
        check("reset busy", gi[0].busy, 1'b0);
        check("reset ovf", gi[0].ovf, 1'b0);
        check("reset ready", gi[0].bus.WR_READY, 1'b1);
        rst_n = 1'b1;
        idle(2);

        // single write to LED1
        cyc(1'b1, 2'd1, 8'h5A);
        idle(12);

        // three back-to-back writes to each board
        cyc(1'b1, 2'd0, 8'h3F);
        cyc(1'b1, 2'd1, 8'h12);
        cyc(1'b1, 2'd2, 8'h34);
        idle(30);

        // broadcast
        cyc(1'b1, 2'd3, 8'hA5);
        idle(12);

        // overflow: six consecutive writes, last one dropped on the default instance
        for (int i = 0; i < 6; i++) cyc(1'b1, 2'(i % 3), 8'(8'h60 + i));
        idle(1);
        check("ovf sticky", gi[0].ovf, 1'b1);
        idle(50);

        // reset while a strobe is low with entries still queued
        cyc(1'b1, 2'd0, 8'h11);
        cyc(1'b1, 2'd1, 8'h22);
        cyc(1'b1, 2'd2, 8'h33);
        for (int i = 0; i < 40 && gi[0].led_latch == 3'b111; i++) cyc(1'b0, 2'd0, 8'h00);
        check("strobe seen before reset", gi[0].led_latch != 3'b111, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async reset latch", gi[0].led_latch, 3'b111);
        check("async reset data", gi[0].led_data, 8'h00);
        check("async reset busy", gi[0].busy, 1'b0);
        check("async reset ovf", gi[0].ovf, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        cyc(1'b1, 2'd2, 8'hC3);
        idle(15);

        // randomized traffic with one reset pulse in the middle
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                @(negedge clk);
                wr_en = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cyc(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
        idle(60);

        check("i0 scoreboard drained", gi[0].sb_edge.size(), 0);
        check("i1 scoreboard drained", gi[1].sb_edge.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
